// File: rtl/regfile_mp.sv
// Dual-write / dual-read register file with same-cycle write bypass, a per-entry
// busy scoreboard and a hardware clear sweep that zeroes the array after reset or on request.

module regfile_mp_rd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              run_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] waddr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] waddr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic [DATA_W-1:0] ent_i,
    input  logic              busy_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rbusy_o
);
    // Port 1 bypass is checked first so it wins over port 0, matching the array write order.
    always_comb begin
        rdata_o = '0;
        if ((ZERO_REG != 0) && (raddr_i == '0))
            rdata_o = '0;
        else if (!run_i)
            rdata_o = '0;
        else if (we1_i && (waddr1_i == raddr_i))
            rdata_o = wdata1_i;
        else if (we0_i && (waddr0_i == raddr_i))
            rdata_o = wdata0_i;
        else
            rdata_o = ent_i;
    end

    assign rbusy_o = run_i & busy_i;
endmodule

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              ready,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rbusy0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rbusy1,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NUM_RD = 2;
    localparam bit ZR     = (ZERO_REG != 0);

    typedef enum logic {SWEEP, RUN} state_e;

    state_e                        state_q;
    logic [ADDR_W-1:0]             cnt_q;
    logic                          ready_q;
    logic [DEPTH-1:0]              busy_q, busy_d;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_q;
    logic                          run;
    logic                          wr0_ok, wr1_ok, iss_ok;

    assign run    = (state_q == RUN);
    assign wr0_ok = run && we0 && !(ZR && (waddr0 == '0));
    assign wr1_ok = run && we1 && !(ZR && (waddr1 == '0));
    assign iss_ok = run && iss_valid && !(ZR && (iss_addr == '0));
    assign ready  = ready_q;

    // Set after clear: an issue landing on an entry being written keeps it pending.
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            if (we0) busy_d[waddr0] = 1'b0;
            if (we1) busy_d[waddr1] = 1'b0;
            if (iss_ok) busy_d[iss_addr] = 1'b1;
            if (clr_req) busy_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            busy_q <= busy_d;
            case (state_q)
                SWEEP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        state_q <= SWEEP;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= SWEEP;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset; the sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wr0_ok) mem_q[waddr0] <= wdata0;
            if (wr1_ok) mem_q[waddr1] <= wdata1;
        end
    end

    logic [NUM_RD-1:0][ADDR_W-1:0] raddr_v;
    logic [NUM_RD-1:0][DATA_W-1:0] rdata_v;
    logic [NUM_RD-1:0]             rbusy_v;

    assign raddr_v = {raddr1, raddr0};

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_mp_rd #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .run_i    (run),
            .raddr_i  (raddr_v[g]),
            .we0_i    (we0),
            .waddr0_i (waddr0),
            .wdata0_i (wdata0),
            .we1_i    (we1),
            .waddr1_i (waddr1),
            .wdata1_i (wdata1),
            .ent_i    (mem_q[raddr_v[g]]),
            .busy_i   (busy_q[raddr_v[g]]),
            .rdata_o  (rdata_v[g]),
            .rbusy_o  (rbusy_v[g])
        );
    end

    assign rdata0 = rdata_v[0];
    assign rdata1 = rdata_v[1];
    assign rbusy0 = rbusy_v[0];
    assign rbusy1 = rbusy_v[1];
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised general-purpose register file for the pipelined CPU.
- Dual write ports and dual read ports.
- Same-cycle write-to-read bypass on both read ports.
- Per-entry busy scoreboard for hazard detection.
- Hardware clear sweep that zeroes every entry after reset or on request.
- Sits between decode (read/issue) and writeback (write).

Parameters:
DATA_W, 32, width of each register
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes, never busy

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous active-low reset
clr_req  in  1  start a clear sweep (sampled in RUN only)
ready  out  1  1 = RUN state; writes and issues accepted
we0  in  1  write enable, port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
raddr0  in  ADDR_W  read address, port 0
rdata0  out  DATA_W  read data, port 0 (combinational)
rbusy0  out  1  scoreboard bit of raddr0 (combinational)
raddr1  in  ADDR_W  read address, port 1
rdata1  out  DATA_W  read data, port 1 (combinational)
rbusy1  out  1  scoreboard bit of raddr1 (combinational)
iss_valid  in  1  mark iss_addr as pending write
iss_addr  in  ADDR_W  destination being issued

Behaviour:

Reset (rst=0, asynchronous):
- state=SWEEP, sweep counter=0, all busy bits=0, ready=0.
- The array itself is not reset; the sweep zeroes it.

FSM states: SWEEP, RUN.

SWEEP:
- Each cycle write 0 to entry[cnt], then cnt++.
- When cnt==DEPTH-1, the final entry is written and state goes to RUN the next cycle.
- Duration is exactly DEPTH cycles after reset release. ready rises on cycle DEPTH+1.
- we0, we1, iss_valid and clr_req are ignored.
- rdata0/1=0 and rbusy0/1=0.

RUN:
- ready=1.
- clr_req=1 -> SWEEP next cycle with cnt=0 and all busy bits cleared that edge. Writes and issues presented in that same cycle are still performed; the sweep then overwrites the data.

Writes (RUN only):
- On posedge, entry[waddrN] <= wdataN when weN=1.
- Both ports to the same address: port 1 wins.
- With ZERO_REG=1, writes to address 0 are discarded.

Reads (combinational) for port k, in priority order:
1. ZERO_REG && raddrk==0 -> 0.
2. state==SWEEP -> 0.
3. we1 && waddr1==raddrk -> wdata1.
4. we0 && waddr0==raddrk -> wdata0.
5. Otherwise entry[raddrk].

Scoreboard (RUN only), per entry, evaluated on posedge:
- Set the busy bit if iss_valid && iss_addr==i.
- Clear it if (we0 && waddr0==i) || (we1 && waddr1==i).
- Issue and write to the same entry in one cycle: the bit stays 1 (the new pending write supersedes).
- With ZERO_REG=1, entry 0 is never set.
- rbusyk = busy[raddrk]. It shows the registered value only; no bypass of same-cycle issue or clear.

General rules:
- No width conversion; all data is DATA_W.
- Addresses always lie within DEPTH, so no bounds check is needed.
- Reset asserted mid-sweep or mid-run restarts the sweep from entry 0.
- A write to a busy register that was not issued is legal and clears the bit.

Test Plan:
1. Release rst, poll ready -> ready=0 for 32 cycles, 1 on cycle 33. Reading every address then returns 0x00000000.
2. RUN: we0=1, waddr0=5, wdata0=0xDEADBEEF with raddr0=5 same cycle -> rdata0=0xDEADBEEF combinationally. Next cycle with we0=0 -> still 0xDEADBEEF.
3. we0 and we1 both to address 7 (0x11111111, 0x22222222), then read 7 -> 0x22222222. Same-cycle bypass also returns 0x22222222.
4. Write 0xFFFFFFFF to address 0, read address 0 on both ports -> 0. iss_valid to address 0 -> rbusy stays 0.
5. Scoreboard:
   - iss_valid with iss_addr=9 -> rbusy0=1 next cycle (raddr0=9).
   - we1 to 9 -> rbusy0=0 the cycle after.
   - Issue and write to 9 in one cycle -> rbusy0=1.
6. Interrupts and mid-operation reset:
   - Write 0x12345678 to address 3, set busy on 4, pulse clr_req -> ready=0 for 32 cycles, rbusy=0 immediately after the edge, address 3 reads 0 after the sweep.
   - Repeat, asserting rst at sweep cycle 10 -> the full 32-cycle sweep restarts.
